sha2_msg_schedule: RTL
======================

SHA2_MSG_SCHEDULE -- requirements
Module: sha2_msg_schedule

Interface
REQ-001 Parameter WIDTH, default 32; word width in bits; 32 for SHA-224/256, 64 for SHA-384/512.
REQ-002 Parameter MODE, default 256; 224/256 select 64 rounds and 32-bit sigma constants; 384/512 select 80 rounds and 64-bit constants; any other value behaves as 256.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin loading a new 16-word block.
REQ-006 in_valid  input  1  in_word holds a valid padded message word.
REQ-007 in_ready  output  1  block accepts an input word this cycle.
REQ-008 in_word  input  WIDTH  padded message word from the padding stage, MSW first (W0..W15).
REQ-009 out_valid  output  1  out_word holds schedule word W[t].
REQ-010 out_ready  input  1  round core consumes out_word this cycle.
REQ-011 out_word  output  WIDTH  schedule word W[t].
REQ-012 out_round  output  7  current index t, 0..ROUNDS-1.
REQ-013 busy  output  1  high in LOAD or RUN.
REQ-014 done  output  1  one-cycle pulse after W[ROUNDS-1] is consumed.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> LOAD with the load counter cleared.
REQ-017 LOAD: in_ready=1; each cycle with in_valid=1 writes in_word to window slot w[cnt] and increments cnt; the 16th accepted word -> RUN with out_round=0.
REQ-018 LOAD: in_valid=0 cycles hold all state; no timeout.
REQ-019 RUN: out_valid=1, in_ready=0, out_word=w[0] (registered, no combinational path from inputs).
REQ-020 RUN handshake (out_valid & out_ready): w[i]<=w[i+1] for i=0..14; w[15]<=sigma1(w[14])+w[9]+sigma0(w[1])+w[0], sum modulo 2^WIDTH; out_round increments.
REQ-021 RUN with out_ready=0: window, out_word and out_round SHALL hold.
REQ-022 WIDTH=32: sigma0=ROTR7^ROTR18^SHR3, sigma1=ROTR17^ROTR19^SHR10.
REQ-023 WIDTH=64: sigma0=ROTR1^ROTR8^SHR7, sigma1=ROTR19^ROTR61^SHR6.
REQ-024 Handshake with out_round=ROUNDS-1 -> IDLE; done=1 in the following cycle only.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 in_valid outside LOAD SHALL be ignored; window unaffected.
REQ-027 Latency: first out_valid one cycle after the 16th input handshake; one word per cycle at full throughput.
REQ-028 start and final handshake in the same cycle: start ignored, FSM -> IDLE.

Reset
REQ-029 rst=0 at a clock edge -> IDLE, cnt=0, out_round=0, window cleared to 0, in_ready=0, out_valid=0, busy=0, done=0, out_word=0.
REQ-030 rst=0 mid-LOAD or mid-RUN aborts the block; no done pulse; a fresh start is needed afterwards.

Verification
REQ-031 SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> W0..W15 echoed, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; done pulse after 64 words.
REQ-032 Same block, out_ready toggled 1/0 every cycle -> identical word sequence, 128 cycles in RUN, out_word stable while out_ready=0.
REQ-033 LOAD with in_valid gaps (3 idle cycles between words) -> same output as REQ-031; in_ready=0 immediately after the 16th word.
REQ-034 rst=0 asserted at out_round=20 -> next cycle all outputs 0, state IDLE; new start plus block completes normally.
REQ-035 WIDTH=64, MODE=512, "abc" block (W0=0x6162638000000000, W15=0x18) -> 80 words, out_round ends at 79, W16=0x6162638000000000, single done pulse.
REQ-036 start pulsed during RUN and in_valid pulsed during RUN -> no state change; sequence identical to REQ-031.

Source files
------------

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule generator.
// Loads a 16-word padded block, then streams W[0..ROUNDS-1] to the round core
// over a valid/ready handshake, expanding W[16..] from a 16-word sliding window.
module sha2_msg_schedule #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [6:0]       out_round,
  output logic             busy,
  output logic             done
);

  // SHA-384/512 run 80 rounds; every other MODE value falls back to 64.
  localparam int         ROUNDS     = (MODE == 384 || MODE == 512) ? 80 : 64;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  // Small sigma functions; the rotate/shift set follows the word width.
  function automatic word_t sigma0(input word_t x);
    if (WIDTH == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else             return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    if (WIDTH == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else             return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] round_q, round_d;
  logic       done_q, done_d;
  word_t      w_q [16];
  word_t      w_d [16];
  word_t      w_new;

  // Next schedule word, appended at the top of the window on each handshake.
  assign w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

  // State register, window and counters; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the window is an explicit reset target because out_word must read 0
    // straight out of reset; a pure datapath RAM would normally be left unreset.
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      w_q     <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end

  // Next-state logic: load slots in order, then shift the window per handshake.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    done_d  = 1'b0;
    w_d     = w_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_d[cnt_q] = in_word;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_RUN;
            round_d = '0;
          end
        end
      end
      S_RUN: begin
        if (out_ready) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = w_new;
          if (round_q == LAST_ROUND) begin
            // Final word consumed: start in this same cycle is not honoured.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 7'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_RUN);
  assign out_word  = w_q[0];
  assign out_round = round_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
